// File: rtl/casu_ep_ctrl.sv
// casu_ep_ctrl: programs the CASU executable-pointer pair (ER_min at word
// offset 0, ER_max at word offset 1) over the openMSP430 peripheral bus on
// behalf of an update agent. The CPU always owns the bus when it asserts
// cpu_per_en; the controller only uses cycles the CPU leaves free.
//
// Optional feature macro: CASU_EP_CTRL_VERIFY_EN
//   defined   -> both registers are read back after writing; upd_err may be 3
//   undefined -> WR_MAX completes the sequence; no readback logic
//
// Ports:
//   mclk, puc_rst              clock, asynchronous active-high reset
//   upd_req/upd_min/upd_max    single-cycle request with the new range
//   upd_busy/upd_done/upd_err  sequencing status, done pulse, error code
//                              (0 none, 1 range, 2 timeout, 3 verify)
//   cpu_per_*                  CPU side of the peripheral bus
//   per_*                      muxed bus toward the pointer register block
module casu_ep_ctrl #(
  parameter logic [14:0] EP_BASE_ADDR = 15'h0140,
  parameter logic [7:0]  WAIT_MAX     = 8'd255
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        upd_req,
  input  logic [15:0] upd_min,
  input  logic [15:0] upd_max,
  output logic        upd_busy,
  output logic        upd_done,
  output logic [1:0]  upd_err,
  input  logic [13:0] cpu_per_addr,
  input  logic [15:0] cpu_per_din,
  input  logic        cpu_per_en,
  input  logic [1:0]  cpu_per_we,
  output logic [15:0] cpu_per_dout,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);

  localparam logic [13:0] ADDR_MIN    = EP_BASE_ADDR[14:1];
  localparam logic [13:0] ADDR_MAX    = ADDR_MIN + 14'd1;
  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_RANGE   = 2'd1;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
`ifdef CASU_EP_CTRL_VERIFY_EN
  localparam logic [1:0]  ERR_VERIFY  = 2'd3;
`endif

  typedef enum logic [2:0] {
    IDLE, CHECK, WR_MIN, WR_MAX, RD_MIN, RD_MAX, DONE, ERR
  } state_t;

  state_t      state;
  logic [15:0] lat_min;
  logic [15:0] lat_max;
  logic [7:0]  wait_cnt;

  // Controller-side bus request derived from the current state
  logic        ctrl_acc;
  logic [13:0] ctrl_addr;
  logic [15:0] ctrl_din;
  logic [1:0]  ctrl_we;
  state_t      grant_next;
  logic        grant_fail;
  logic [8:0]  wait_inc;
  logic        timeout;

  // Per-state access description and where a granted cycle leads
  always_comb begin
    ctrl_acc   = 1'b0;
    ctrl_addr  = 14'd0;
    ctrl_din   = 16'd0;
    ctrl_we    = 2'b00;
    grant_next = IDLE;
    grant_fail = 1'b0;
    case (state)
      WR_MIN: begin
        ctrl_acc   = 1'b1;
        ctrl_addr  = ADDR_MIN;
        ctrl_din   = lat_min;
        ctrl_we    = 2'b11;
        grant_next = WR_MAX;
      end
      WR_MAX: begin
        ctrl_acc   = 1'b1;
        ctrl_addr  = ADDR_MAX;
        ctrl_din   = lat_max;
        ctrl_we    = 2'b11;
`ifdef CASU_EP_CTRL_VERIFY_EN
        grant_next = RD_MIN;
`else
        grant_next = DONE;
`endif
      end
`ifdef CASU_EP_CTRL_VERIFY_EN
      // Register block read is combinational: compare in the granted cycle
      RD_MIN: begin
        ctrl_acc   = 1'b1;
        ctrl_addr  = ADDR_MIN;
        grant_next = RD_MAX;
        grant_fail = (per_dout != lat_min);
      end
      RD_MAX: begin
        ctrl_acc   = 1'b1;
        ctrl_addr  = ADDR_MAX;
        grant_next = DONE;
        grant_fail = (per_dout != lat_max);
      end
`endif
      default: ;
    endcase
  end

  // The cycle that would bring the counter up to WAIT_MAX is the timeout
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;
  assign timeout  = (wait_inc >= {1'b0, WAIT_MAX});

  // Bus mux: CPU has absolute priority, idle bus is driven to zero
  always_comb begin
    per_en   = 1'b0;
    per_we   = 2'b00;
    per_addr = 14'd0;
    per_din  = 16'd0;
    if (cpu_per_en) begin
      per_en   = 1'b1;
      per_we   = cpu_per_we;
      per_addr = cpu_per_addr;
      per_din  = cpu_per_din;
    end else if (ctrl_acc) begin
      per_en   = 1'b1;
      per_we   = ctrl_we;
      per_addr = ctrl_addr;
      per_din  = ctrl_din;
    end
  end

  assign cpu_per_dout = per_dout;

  // Sequencer with registered status outputs
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state    <= IDLE;
      lat_min  <= 16'd0;
      lat_max  <= 16'd0;
      wait_cnt <= 8'd0;
      upd_busy <= 1'b0;
      upd_done <= 1'b0;
      upd_err  <= ERR_NONE;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_req) begin
            lat_min  <= upd_min;
            lat_max  <= upd_max;
            upd_err  <= ERR_NONE;
            upd_busy <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (lat_min > lat_max) begin
            upd_err <= ERR_RANGE;
            state   <= ERR;
          end else begin
            state   <= WR_MIN;
          end
        end
        WR_MIN, WR_MAX, RD_MIN, RD_MAX: begin
          if (!cpu_per_en) begin
            wait_cnt <= 8'd0;
`ifdef CASU_EP_CTRL_VERIFY_EN
            if (grant_fail) begin
              upd_err <= ERR_VERIFY;
              state   <= ERR;
            end else begin
              upd_done <= (grant_next == DONE);
              state    <= grant_next;
            end
`else
            upd_done <= (grant_next == DONE) & ~grant_fail;
            state    <= grant_next;
`endif
          end else if (timeout) begin
            wait_cnt <= 8'd0;
            upd_err  <= ERR_TIMEOUT;
            state    <= ERR;
          end else begin
            wait_cnt <= wait_inc[7:0];
          end
        end
        DONE, ERR: begin
          upd_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          upd_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_casu_ep_ctrl.sv
// Self-checking bench for casu_ep_ctrl: a transaction-level model (queue of
// pending bus accesses per request) predicts status and bus mux outputs every
// cycle; directed scenarios pin the model with literal expectations, then a
// randomized phase mixes requests with random CPU traffic.
module tb_casu_ep_ctrl;

  localparam logic [7:0]  TB_WAIT_MAX = 8'd4;
  localparam logic [13:0] A_MIN = 14'h00A0;
  localparam logic [13:0] A_MAX = 14'h00A1;
`ifdef CASU_EP_CTRL_VERIFY_EN
  localparam int NACC = 4;
`else
  localparam int NACC = 2;
`endif

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        upd_req = 1'b0;
  logic [15:0] upd_min = 16'd0;
  logic [15:0] upd_max = 16'd0;
  logic        upd_busy, upd_done;
  logic [1:0]  upd_err;
  logic [13:0] cpu_per_addr = 14'd0;
  logic [15:0] cpu_per_din = 16'd0;
  logic        cpu_per_en = 1'b0;
  logic [1:0]  cpu_per_we = 2'b00;
  logic [15:0] cpu_per_dout;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  wire  [15:0] per_dout;

  casu_ep_ctrl #(.EP_BASE_ADDR(15'h0140), .WAIT_MAX(TB_WAIT_MAX)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .upd_req(upd_req), .upd_min(upd_min), .upd_max(upd_max),
    .upd_busy(upd_busy), .upd_done(upd_done), .upd_err(upd_err),
    .cpu_per_addr(cpu_per_addr), .cpu_per_din(cpu_per_din),
    .cpu_per_en(cpu_per_en), .cpu_per_we(cpu_per_we), .cpu_per_dout(cpu_per_dout),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
    .per_we(per_we), .per_dout(per_dout)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pointer register block stand-in: two word registers, combinational read
  logic [15:0] r_min, r_max;
  logic        corrupt = 1'b0;
  int          bus_cnt = 0;
  int          done_cnt = 0;

  assign per_dout = (corrupt && per_addr == A_MAX) ? 16'h1234 :
                    (per_addr == A_MIN) ? r_min :
                    (per_addr == A_MAX) ? r_max : 16'h0000;

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_min <= 16'd0;
      r_max <= 16'd0;
    end else if (per_en) begin
      if (per_addr == A_MIN) begin
        if (per_we[0]) r_min[7:0]  <= per_din[7:0];
        if (per_we[1]) r_min[15:8] <= per_din[15:8];
      end
      if (per_addr == A_MAX) begin
        if (per_we[0]) r_max[7:0]  <= per_din[7:0];
        if (per_we[1]) r_max[15:8] <= per_din[15:8];
      end
    end
  end

  always @(posedge mclk) if (!puc_rst && per_en && !cpu_per_en) bus_cnt <= bus_cnt + 1;
  always @(negedge mclk) if (!puc_rst && upd_done) done_cnt <= done_cnt + 1;

  // Behavioural model: phase 0 idle, 1 range check, 2 accesses pending, 3 finishing
  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        q[$];
  int          m_phase = 0;
  int          m_wait = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [1:0]  m_err = 2'd0;
  logic [15:0] m_min = 16'd0, m_max = 16'd0;

  initial forever begin
    @(posedge mclk or posedge puc_rst);
    if (puc_rst) begin
      m_phase = 0; m_wait = 0; q.delete();
      m_busy = 1'b0; m_done = 1'b0; m_err = 2'd0;
      m_min = 16'd0; m_max = 16'd0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (upd_req) begin
          m_min = upd_min; m_max = upd_max; m_err = 2'd0;
          q.delete();
          q.push_back('{1'b1, A_MIN, upd_min});
          q.push_back('{1'b1, A_MAX, upd_max});
`ifdef CASU_EP_CTRL_VERIFY_EN
          q.push_back('{1'b0, A_MIN, upd_min});
          q.push_back('{1'b0, A_MAX, upd_max});
`endif
          m_phase = 1;
        end
        1: if (m_min > m_max) begin m_err = 2'd1; m_phase = 3; end
           else m_phase = 2;
        2: if (!cpu_per_en) begin
          m_wait = 0;
          if (!q[0].wr && per_dout != q[0].data) begin
            m_err = 2'd3; m_phase = 3;
          end else begin
            void'(q.pop_front());
            if (q.size() == 0) begin m_done = 1'b1; m_phase = 3; end
          end
        end else begin
          m_wait++;
          if (m_wait >= int'(TB_WAIT_MAX)) begin m_err = 2'd2; m_wait = 0; m_phase = 3; end
        end
        default: m_phase = 0;
      endcase
      m_busy = (m_phase != 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    logic        e_en;
    logic [1:0]  e_we;
    logic [13:0] e_addr;
    logic [15:0] e_din;
    @(negedge mclk);
    if (!puc_rst) begin
      chk("upd_busy", 32'(upd_busy), 32'(m_busy));
      chk("upd_done", 32'(upd_done), 32'(m_done));
      chk("upd_err", 32'(upd_err), 32'(m_err));
      e_en = 1'b0; e_we = 2'b00; e_addr = 14'd0; e_din = 16'd0;
      if (cpu_per_en) begin
        e_en = 1'b1; e_we = cpu_per_we; e_addr = cpu_per_addr; e_din = cpu_per_din;
      end else if (m_phase == 2 && q.size() > 0) begin
        e_en = 1'b1; e_addr = q[0].addr;
        e_we = q[0].wr ? 2'b11 : 2'b00;
        e_din = q[0].wr ? q[0].data : 16'd0;
      end
      chk("per_en", 32'(per_en), 32'(e_en));
      chk("per_we", 32'(per_we), 32'(e_we));
      chk("per_addr", 32'(per_addr), 32'(e_addr));
      chk("per_din", 32'(per_din), 32'(e_din));
      chk("cpu_per_dout", 32'(cpu_per_dout), 32'(per_dout));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge mclk); #1;
  endtask

  task automatic start_req(input logic [15:0] mn, input logic [15:0] mx);
    tick();
    upd_req = 1'b1; upd_min = mn; upd_max = mx;
    tick();
    upd_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (m_phase != 0 && n < 200) begin tick(); n++; end
    if (m_phase != 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: model still busy after %0d cycles, required idle", name, n);
    end
    tick();
  endtask

  initial begin
    int b0, d0, n, dens;
    logic [15:0] a, b, t;
    repeat (3) tick();
    chk("reset_busy", 32'(upd_busy), 32'd0);
    chk("reset_done", 32'(upd_done), 32'd0);
    chk("reset_err", 32'(upd_err), 32'd0);
    puc_rst = 1'b0;
    tick();

    // Idle bus, legal range
    b0 = bus_cnt; d0 = done_cnt;
    start_req(16'hE000, 16'hEFFF);
    wait_idle("idle_seq");
    chk("idle_err", 32'(upd_err), 32'd0);
    chk("idle_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("idle_bus_cnt", 32'(bus_cnt - b0), 32'(NACC));
    chk("idle_r_min", 32'(r_min), 32'h0000E000);
    chk("idle_r_max", 32'(r_max), 32'h0000EFFF);

    // Inverted range
    b0 = bus_cnt; d0 = done_cnt;
    start_req(16'hF000, 16'hE000);
    wait_idle("range_seq");
    chk("range_err", 32'(upd_err), 32'd1);
    chk("range_bus_cnt", 32'(bus_cnt - b0), 32'd0);
    chk("range_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Equal bounds are legal
    start_req(16'hC123, 16'hC123);
    wait_idle("equal_seq");
    chk("equal_err", 32'(upd_err), 32'd0);
    chk("equal_r_max", 32'(r_max), 32'h0000C123);

    // CPU occupies the bus for 3 cycles during WR_MIN
    b0 = bus_cnt; d0 = done_cnt;
    start_req(16'hD000, 16'hD0FF);
    tick();
    cpu_per_en = 1'b1; cpu_per_addr = 14'h0010; cpu_per_we = 2'b11; cpu_per_din = 16'hA5A5;
    repeat (3) tick();
    cpu_per_en = 1'b0; cpu_per_we = 2'b00;
    wait_idle("cpu3_seq");
    chk("cpu3_err", 32'(upd_err), 32'd0);
    chk("cpu3_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("cpu3_bus_cnt", 32'(bus_cnt - b0), 32'(NACC));
    chk("cpu3_r_min", 32'(r_min), 32'h0000D000);

    // CPU never releases: timeout after WAIT_MAX denied cycles
    b0 = bus_cnt;
    cpu_per_en = 1'b1; cpu_per_addr = 14'h0010; cpu_per_we = 2'b00;
    start_req(16'hE000, 16'hEFFF);
    wait_idle("timeout_seq");
    chk("timeout_err", 32'(upd_err), 32'd2);
    chk("timeout_busy", 32'(upd_busy), 32'd0);
    chk("timeout_bus_cnt", 32'(bus_cnt - b0), 32'd0);
    cpu_per_en = 1'b0;
    tick();

`ifdef CASU_EP_CTRL_VERIFY_EN
    // Corrupted readback of ER_max
    d0 = done_cnt;
    start_req(16'hE000, 16'hEFFF);
    n = 0;
    while (!(m_phase == 2 && q.size() == 1) && n < 50) begin tick(); n++; end
    corrupt = 1'b1;
    wait_idle("verify_seq");
    corrupt = 1'b0;
    chk("verify_err", 32'(upd_err), 32'd3);
    chk("verify_done_cnt", 32'(done_cnt - d0), 32'd0);
    chk("verify_r_max", 32'(r_max), 32'h0000EFFF);
`endif

    // Reset while writing ER_max aborts the sequence
    start_req(16'hE100, 16'hE1FF);
    n = 0;
    while (!(m_phase == 2 && q.size() == NACC - 1) && n < 50) begin tick(); n++; end
    chk("rst_reached_wrmax", 32'(m_phase), 32'd2);
    #2 puc_rst = 1'b1;
    #1;
    chk("rst_busy", 32'(upd_busy), 32'd0);
    chk("rst_err", 32'(upd_err), 32'd0);
    chk("rst_done", 32'(upd_done), 32'd0);
    chk("rst_per_en", 32'(per_en), 32'd0);
    tick();
    puc_rst = 1'b0;
    chk("rst_r_min", 32'(r_min), 32'd0);
    d0 = done_cnt;
    start_req(16'hE100, 16'hE1FF);
    wait_idle("post_rst_seq");
    chk("post_rst_err", 32'(upd_err), 32'd0);
    chk("post_rst_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("post_rst_r_min", 32'(r_min), 32'h0000E100);
    chk("post_rst_r_max", 32'(r_max), 32'h0000E1FF);

    // Randomized traffic: requests at any time, CPU load varying by window
    dens = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 0;
          1: dens = 20;
          2: dens = 60;
          default: dens = 95;
        endcase
      end
      a = 16'($urandom); b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: ;
        default: if (a > b) begin t = a; a = b; b = t; end
      endcase
      upd_req = ($urandom_range(0, 5) == 0);
      upd_min = a; upd_max = b;
      cpu_per_en = ($urandom_range(0, 99) < dens);
      cpu_per_addr = ($urandom_range(0, 3) == 0) ? (A_MIN + 14'($urandom_range(0, 1)))
                                                 : 14'($urandom);
      cpu_per_we = 2'($urandom);
      cpu_per_din = 16'($urandom);
      tick();
    end
    upd_req = 1'b0; cpu_per_en = 1'b0; cpu_per_we = 2'b00;
    wait_idle("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
